toggle_power_monitor: RTL and testbench
=======================================

# toggle_power_monitor

Multi-channel switching-activity and dynamic-power monitor. Samples N_CH gate outputs on every clock edge and counts transitions per channel in saturating counters. At the end of each fixed window of WIN_LEN cycles it reports the window's dynamic energy: total toggles × E_PER_TOGGLE, where E_PER_TOGGLE encodes C_L·Vcc². It sits beside the gate-level models in the testbench/analysis layer and replaces per-gate ad-hoc power printing with one clocked, resettable, windowed measurement.

## Interface
- N_CH, 4: number of monitored signals
- CNT_W, 8: per-channel toggle counter width
- E_W, 24: energy output width
- WIN_LEN, 16: window length in RUN cycles, ≥ 2
- E_PER_TOGGLE, 125: energy units per toggle (125 = 50 pF·25 V² = 1.25 nJ, expressed in 10 pJ units)
- clk  in  1  rising-edge clock
- reset_L  in  1  asynchronous, active-low reset
- enable  in  1  run measurement
- clear  in  1  synchronous clear, highest priority after reset
- sig_in  in  N_CH  monitored signals
- sel  in  $clog2(N_CH) (min 1)  channel select for readout
- tog_cnt  out  CNT_W  current count of channel sel
- win_energy  out  E_W  energy of last completed window
- win_valid  out  1  one-cycle pulse, win_energy updated
- sat  out  N_CH+1  sticky saturation flags; bits [N_CH-1:0] are the channels, bit N_CH is energy

## Operation
- FSM states:
  - IDLE: nothing counts. Goes to PRIME when enable=1.
  - PRIME: one cycle; loads prev ← sig_in, no count. Goes to RUN if enable=1, else IDLE.
  - RUN: each edge, tog_i = sig_in[i] ^ prev[i]; count_i += tog_i with saturation; prev ← sig_in; win_cnt increments. enable=0 goes to IDLE, holding counts and win_cnt.
- Window end occurs on the RUN edge where win_cnt = WIN_LEN-1. On that edge:
  - sum = Σ(count_i + tog_i), width CNT_W+$clog2(N_CH)+1
  - win_energy ← sum × E_PER_TOGGLE, saturated to 2^E_W-1 (sets sat[N_CH])
  - win_valid ← 1
  - all count_i ← 0, win_cnt ← 0
  - FSM stays in RUN
- A count_i at 2^CNT_W-1 holds its value and sets sat[i].
- sat bits are sticky until clear or reset.
- tog_cnt = count[sel], combinational from registers; sel ≥ N_CH gives 0.
- clear=1: counts, win_cnt, prev, sat, win_energy and win_valid go to 0, FSM to IDLE, regardless of enable.
- Reset mid-window discards the partial window; no win_valid is produced.
- Re-enable after IDLE always passes through PRIME, so a change during disable is never counted.

## Timing
- Reset values: tog_cnt=0, win_energy=0, win_valid=0, sat=0, FSM=IDLE, win_cnt=0.
- Latency enable→first counted edge: 2 edges (IDLE→PRIME, PRIME→RUN); the first RUN edge compares against the PRIME sample.
- A toggle captured on edge k is visible on tog_cnt after edge k.
- win_valid is high for exactly the cycle after the window-end edge. win_energy holds until the next window end, clear or reset.
- Window period in continuous RUN: exactly WIN_LEN edges between win_valid pulses.
- When enable drops at the window-end edge, the report still happens and FSM then enters IDLE.

## Structure
- Package pwr_mon_pkg holds:
  - state enum {IDLE, PRIME, RUN}
  - default constants C_L_UNITS, VCC_SQ, E_PER_TOGGLE_DEF
  - saturating-add function
- Sub-module toggle_counter: per-channel prev flop, XOR detect, saturating CNT_W counter, sat flag, with inputs prime/count_en/win_clr/clear. Instantiated N_CH times via generate. The top holds the FSM, window counter, adder tree and multiplier.

## Test plan
- Reset → all outputs 0. Enable with sig_in constant for 16 RUN cycles → win_valid pulse, win_energy=0.
- Channel 0 toggling every cycle, others static, WIN_LEN=16 → win_energy=16×125=2000; sel=0 mid-window shows a rising count; sel=1 reads 0.
- All 4 channels toggling every cycle → win_energy=64×125=8000. The next window gives the same value, with pulses exactly 16 cycles apart.
- CNT_W=4, channel 2 toggling for 20 cycles with WIN_LEN=32 → tog_cnt(sel=2) sticks at 15 and sat[2]=1. sat[2] stays 1 after the window; clear drops it to 0.
- Drop enable at window cycle 5, toggle sig_in while disabled, re-enable → the disabled-period change is not counted; the window completes 11 RUN cycles after PRIME.
- Assert reset_L=0 asynchronously mid-window (between edges) → outputs 0 immediately, no win_valid, and the next window starts from 0 after PRIME.

Source files
------------

// File: rtl/pwr_mon_pkg.sv
// rtl/pwr_mon_pkg.sv - shared types, energy constants and saturating add for toggle_power_monitor
package pwr_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_e;

    // C_L in pF times Vcc^2 in V^2 gives pJ; divide by 10 for 10 pJ energy units
    localparam int C_L_UNITS        = 50;
    localparam int VCC_SQ           = 25;
    localparam int E_PER_TOGGLE_DEF = (C_L_UNITS * VCC_SQ) / 10;

    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max_v
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[31:0];
    endfunction

endpackage

// File: rtl/toggle_counter.sv
// rtl/toggle_counter.sv - one channel: previous-sample flop, XOR toggle detect, saturating counter, sticky sat
module toggle_counter
    import pwr_mon_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             prime,
    input  logic             count_en,
    input  logic             win_clr,
    input  logic             clear,
    input  logic             sig,
    output logic [CNT_W-1:0] count,
    output logic             tog,
    output logic             sat
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic             prev_q, prev_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    always_comb begin
        tog     = count_en & (sig ^ prev_q);
        prev_d  = prev_q;
        count_d = count_q;
        sat_d   = sat_q;
        if (clear) begin
            prev_d  = 1'b0;
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (prime || count_en) begin
                prev_d = sig;
            end
            if (count_en) begin
                // At window end the live toggle goes to the adder tree, not the counter
                if (win_clr) begin
                    count_d = '0;
                end else begin
                    count_d = CNT_W'(sat_add(32'(count_q), {31'b0, tog}, CNT_MAX));
                end
                if (tog && (32'(count_q) == CNT_MAX)) begin
                    sat_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            prev_q  <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/toggle_power_monitor.sv
// rtl/toggle_power_monitor.sv - windowed multi-channel toggle counter with per-window dynamic energy report
module toggle_power_monitor
    import pwr_mon_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 8,
    parameter int E_W          = 24,
    parameter int WIN_LEN      = 16,
    parameter int E_PER_TOGGLE = E_PER_TOGGLE_DEF,
    localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             enable,
    input  logic             clear,
    input  logic [N_CH-1:0]  sig_in,
    input  logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] tog_cnt,
    output logic [E_W-1:0]   win_energy,
    output logic             win_valid,
    output logic [N_CH:0]    sat
);

    localparam int WC_W  = $clog2(WIN_LEN);
    localparam int SUM_W = CNT_W + $clog2(N_CH) + 1;
    localparam int P_W   = SUM_W + 32;
    localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WIN_LEN - 1);
    localparam logic [P_W-1:0]  E_MAX    = P_W'({E_W{1'b1}});

    state_e            state_q, state_d;
    logic [WC_W-1:0]   win_cnt_q, win_cnt_d;
    logic [E_W-1:0]    win_energy_q, win_energy_d;
    logic              win_valid_q, win_valid_d;
    logic              sat_e_q, sat_e_d;

    logic              prime, count_en, win_end;
    logic [CNT_W-1:0]  cnt [N_CH];
    logic [N_CH-1:0]   tog, ch_sat;
    logic [SUM_W-1:0]  sum;
    logic [P_W-1:0]    product;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            toggle_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk      (clk),
                .reset_L  (reset_L),
                .prime    (prime),
                .count_en (count_en),
                .win_clr  (win_end),
                .clear    (clear),
                .sig      (sig_in[g]),
                .count    (cnt[g]),
                .tog      (tog[g]),
                .sat      (ch_sat[g])
            );
        end
    endgenerate

    always_comb begin
        prime    = !clear && (state_q == PRIME);
        count_en = !clear && (state_q == RUN);
        win_end  = count_en && (win_cnt_q == WIN_LAST);
    end

    // The window-end sum includes the toggles seen on that same edge
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            sum = sum + SUM_W'(cnt[i]) + SUM_W'(tog[i]);
        end
        product = P_W'(sum) * P_W'(E_PER_TOGGLE);
    end

    always_comb begin
        state_d      = state_q;
        win_cnt_d    = win_cnt_q;
        win_energy_d = win_energy_q;
        win_valid_d  = 1'b0;
        sat_e_d      = sat_e_q;
        if (clear) begin
            state_d      = IDLE;
            win_cnt_d    = '0;
            win_energy_d = '0;
            sat_e_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE:    state_d = enable ? PRIME : IDLE;
                PRIME:   state_d = enable ? RUN : IDLE;
                RUN:     state_d = enable ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
            if (count_en) begin
                win_cnt_d = win_end ? '0 : win_cnt_q + 1'b1;
            end
            if (win_end) begin
                win_valid_d = 1'b1;
                if (product > E_MAX) begin
                    win_energy_d = '1;
                    sat_e_d      = 1'b1;
                end else begin
                    win_energy_d = product[E_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            win_cnt_q    <= '0;
            win_energy_q <= '0;
            win_valid_q  <= 1'b0;
            sat_e_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            win_energy_q <= win_energy_d;
            win_valid_q  <= win_valid_d;
            sat_e_q      <= sat_e_d;
        end
    end

    always_comb begin
        tog_cnt = '0;
        if (32'(sel) < N_CH) begin
            tog_cnt = cnt[sel];
        end
    end

    assign win_energy = win_energy_q;
    assign win_valid  = win_valid_q;
    assign sat        = {sat_e_q, ch_sat};

endmodule

// File: tb/tb_toggle_power_monitor.sv
// tb/tb_toggle_power_monitor.sv - scoreboard bench for toggle_power_monitor
module tb_toggle_power_monitor;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       en_a, clr_a, en_b, clr_b;
    logic [3:0] sig_a, sig_b, tm_a, tm_b;
    logic [1:0] sel_a, sel_b;
    logic [7:0] tc_a;
    logic [3:0] tc_b;
    logic [23:0] we_a, we_b;
    logic       wv_a, wv_b;
    logic [4:0] sat_a, sat_b;

    int n_checks = 0;
    int n_errors = 0;

    int         m_st;
    logic [3:0] m_prev;
    int         m_cnt [4];
    int         m_wc;
    longint     m_energy;
    logic       m_valid;
    logic [4:0] m_sat;
    longint     exp_q [$];
    longint     exp_b [$];

    always #5 clk = ~clk;

    toggle_power_monitor u_dut_a (
        .clk(clk), .reset_L(reset_L), .enable(en_a), .clear(clr_a), .sig_in(sig_a),
        .sel(sel_a), .tog_cnt(tc_a), .win_energy(we_a), .win_valid(wv_a), .sat(sat_a)
    );

    toggle_power_monitor #(.CNT_W(4), .WIN_LEN(32)) u_dut_b (
        .clk(clk), .reset_L(reset_L), .enable(en_b), .clear(clr_b), .sig_in(sig_b),
        .sel(sel_b), .tog_cnt(tc_b), .win_energy(we_b), .win_valid(wv_b), .sat(sat_b)
    );

    task automatic chk(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_prev = '0; m_wc = 0; m_energy = 0; m_valid = 1'b0; m_sat = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        logic [3:0] t;
        longint     s;
        m_valid = 1'b0;
        if (!reset_L || clr_a) begin
            model_reset();
        end else if (m_st == 0) begin
            if (en_a) m_st = 1;
        end else if (m_st == 1) begin
            m_prev = sig_a;
            m_st   = en_a ? 2 : 0;
        end else begin
            t = sig_a ^ m_prev;
            for (int i = 0; i < 4; i++)
                if (t[i] && m_cnt[i] == 255) m_sat[i] = 1'b1;
            if (m_wc == 15) begin
                s = 0;
                for (int i = 0; i < 4; i++) s += m_cnt[i] + t[i];
                m_energy = s * 125;
                if (m_energy > 24'hFFFFFF) begin
                    m_energy = 24'hFFFFFF;
                    m_sat[4] = 1'b1;
                end
                m_valid = 1'b1;
                exp_q.push_back(m_energy);
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
                m_wc = 0;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (t[i] && m_cnt[i] < 255) m_cnt[i]++;
                m_wc++;
            end
            m_prev = sig_a;
            m_st   = en_a ? 2 : 0;
        end
    endtask

    task automatic tick();
        longint e;
        sig_a = sig_a ^ tm_a;
        sig_b = sig_b ^ tm_b;
        @(posedge clk);
        model_step();
        #1;
        chk("valid_a", wv_a, m_valid);
        chk("energy_a", we_a, m_energy);
        chk("tog_cnt_a", tc_a, m_cnt[sel_a]);
        chk("sat_a", sat_a, m_sat);
        if (wv_a) begin
            chk("sb_a_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_a_energy", we_a, e);
            end
        end
        if (wv_b) begin
            chk("sb_b_pending", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                chk("sb_b_energy", we_b, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int k, last, npulse;
        reset_L = 1'b0;
        en_a = 0; clr_a = 0; en_b = 0; clr_b = 0;
        sig_a = '0; sig_b = '0; tm_a = '0; tm_b = '0; sel_a = 0; sel_b = 2;
        model_reset();
        #3;
        chk("rst_tog_cnt", tc_a, 0);
        chk("rst_energy", we_a, 0);
        chk("rst_valid", wv_a, 0);
        chk("rst_sat", sat_a, 0);
        chk("rst_b_sat", sat_b, 0);
        tick(); tick();
        reset_L = 1'b1;

        // static inputs: zero-energy window
        sig_a = 4'b1010; en_a = 1;
        repeat (18) tick();
        chk("t1_valid", wv_a, 1);
        chk("t1_energy", we_a, 0);

        // channel 0 toggling
        tm_a = 4'b0001; sel_a = 0;
        repeat (8) tick();
        chk("t2_mid_cnt", tc_a, 8);
        sel_a = 1;
        tick();
        chk("t2_ch1_zero", tc_a, 0);
        sel_a = 0;
        repeat (7) tick();
        chk("t2_valid", wv_a, 1);
        chk("t2_energy", we_a, 2000);

        // all channels toggling, two windows back to back
        tm_a = 4'b1111; last = -1; npulse = 0;
        for (int j = 1; j <= 32; j++) begin
            tick();
            if (wv_a) begin
                chk("t3_energy", we_a, 8000);
                if (last >= 0) chk("t3_gap", j - last, 16);
                last = j;
                npulse++;
            end
        end
        chk("t3_pulses", npulse, 2);

        // enable dropped on the 5th RUN edge, inputs changed while idle
        clr_a = 1; tm_a = 4'b0000;
        tick();
        clr_a = 0;
        chk("t4_clear_energy", we_a, 0);
        tm_a = 4'b0001;
        repeat (6) tick();
        en_a = 0;
        tick();
        tm_a = 4'b1111;
        repeat (3) tick();
        tm_a = 4'b0001; en_a = 1; k = 0;
        for (int j = 1; j <= 40 && k == 0; j++) begin
            tick();
            if (wv_a) k = j;
        end
        chk("t4_latency", k, 13);
        chk("t4_energy", we_a, 2000);

        // asynchronous reset between edges mid-window
        repeat (5) tick();
        #2;
        reset_L = 1'b0;
        #1;
        chk("t5_tog_cnt", tc_a, 0);
        chk("t5_energy", we_a, 0);
        chk("t5_valid", wv_a, 0);
        chk("t5_sat", sat_a, 0);
        model_reset();
        exp_q.delete();
        tick();
        reset_L = 1'b1; k = 0;
        for (int j = 1; j <= 40 && k == 0; j++) begin
            tick();
            if (wv_a) k = j;
        end
        chk("t5_latency", k, 18);
        chk("t5_energy_after", we_a, 2000);

        // narrow counter saturation on the second instance
        en_a = 0; tm_a = 4'b0000;
        en_b = 1; tm_b = 4'b0100;
        repeat (22) tick();
        tm_b = 4'b0000;
        chk("t6_cnt_stuck", tc_b, 15);
        chk("t6_sat", sat_b, 5'b00100);
        exp_b.push_back(15 * 125);
        repeat (12) tick();
        chk("t6_valid", wv_b, 1);
        chk("t6_sat_sticky", sat_b, 5'b00100);
        clr_b = 1;
        tick();
        clr_b = 0;
        chk("t6_sat_cleared", sat_b, 0);
        chk("t6_energy_cleared", we_b, 0);

        chk("sb_drain", exp_q.size() + exp_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
